mem_ctrl: RTL and testbench
===========================

Name: mem_ctrl

Overview:
- Sits directly upstream of the byte-wide synchronous RAM wrapper (17-bit address, 8-bit data, one-cycle read latency).
- Accepts 32-bit requests from instruction fetch (IF) and from the MEM stage.
- Arbitrates between the two requesters and serialises each 1/2/3/4-byte access into consecutive little-endian byte cycles on the RAM port.
- Reassembles read bytes and returns them with a one-cycle done pulse.

Parameters:
- ADDR_WIDTH, 17, RAM address width; RAM addresses are taken from the low ADDR_WIDTH bits of the request address.

Ports:
- clk  in  1  system clock; all state updates on the rising edge
- rst_n  in  1  synchronous reset, active-low
- if_req_i  in  1  IF read request; held, with stable address, until if_done_o
- if_addr_i  in  32  IF byte address (always a 4-byte read)
- if_done_o  out  1  one-cycle pulse: if_inst_o valid
- if_inst_o  out  32  fetched word, little-endian
- mem_req_i  in  1  MEM request; held, with stable fields, until mem_done_o
- mem_we_i  in  1  1 = write, 0 = read
- mem_len_i  in  2  byte count minus 1 (00=1, 01=2, 10=3, 11=4)
- mem_addr_i  in  32  MEM byte address
- mem_data_i  in  32  write data; byte i = bits [8i+7:8i]
- mem_done_o  out  1  one-cycle pulse: access complete / mem_data_o valid
- mem_data_o  out  32  read data, zero-extended above N bytes
- busy_o  out  1  high whenever state != IDLE
- ram_we_o  out  1  RAM write enable (registered)
- ram_addr_o  out  ADDR_WIDTH  RAM byte address (registered)
- ram_data_o  out  8  RAM write byte (registered)
- ram_data_i  in  8  RAM read byte; valid the cycle after the RAM samples its address

Behaviour:
- Reset (rst_n=0 at an edge):
  - State goes to IDLE.
  - All outputs are 0: ram_we_o, ram_addr_o, ram_data_o, done pulses, if_inst_o, mem_data_o, busy_o.
  - This applies mid-transaction: the access is abandoned with no done pulse, and bytes already written stay in RAM.
- States: IDLE, ISSUE, DRAIN (reads only), then back to IDLE.
- Arbitration:
  - Requests are sampled only in IDLE, and not in a cycle where either done output is high.
  - mem_req_i has priority over if_req_i when both are high.
  - A started access always completes; it is never pre-empted.
- Accept edge E0:
  - Latch the requester, base address, N = len+1 (N = 4 for IF), write data, and direction.
  - Register ram_addr_o = base[ADDR_WIDTH-1:0].
  - For a write, register ram_we_o = 1 and ram_data_o = byte 0.
  - Go to ISSUE, byte index = 0.
- ISSUE, edges E1..E(N-1):
  - ram_addr_o = base + i, modulo 2^ADDR_WIDTH (0x1FFFF + 1 wraps to 0x00000).
  - For writes, ram_data_o = byte i.
- Writes:
  - At edge EN: ram_we_o <= 0, mem_done_o <= 1, state goes to IDLE.
  - The RAM commits bytes at edges E1..EN. Latency is N edges from accept to done.
- Reads:
  - The byte addressed at Ek is captured from ram_data_i at edge E(k+2) into bits [8k+7:8k].
  - After the last address, the state passes through DRAIN.
  - The last byte is captured at E(N+1), and the done pulse plus data register update on the same edge (E(N+1)).
  - Latency is N+1 edges. ram_we_o stays 0 throughout.
- Done:
  - The pulse lasts exactly one cycle.
  - The requester must drop or replace its request during the done cycle.
  - The earliest next accept is the edge ending the done cycle, which is ignored, so the effective earliest accept is the edge after that.
- Data outputs:
  - if_inst_o and mem_data_o update only on their own read completion and hold otherwise.
  - Unread upper bytes are 0.
  - No sign extension; the MEM stage performs it.
- busy_o is high from E0 through the done edge, and low in IDLE.
- No alignment restriction: misaligned multi-byte accesses are legal because transfers are byte-serial.

Test Plan:
- IF read: RAM[0x100..0x103] = 11,22,33,44; if_req at 0x100 -> ram_addr_o = 0x100..0x103 on consecutive cycles; if_done_o pulses 5 edges after accept with if_inst_o = 0x44332211.
- MEM word write: addr 0x200, data 0xDEADBEEF, len 11 -> ram_we_o high 4 cycles with bytes EF,BE,AD,DE at 0x200..0x203; mem_done_o at edge 4; a following read of 0x200 returns 0xDEADBEEF.
- Simultaneous if_req and mem_req (MEM byte read at 0x201 = 0xBE) -> MEM served first, mem_data_o = 0x000000BE at edge 2; IF accepted afterwards, with no overlap in ram_addr_o sequences.
- Wrap: halfword write 0xA1B2 at address 0x1FFFF -> 0xB2 written at 0x1FFFF, 0xA1 at 0x00000; readback of 2 bytes gives 0x0000A1B2.
- Reset mid-write: rst_n=0 after 2 of 4 bytes written -> next edge ram_we_o = 0, busy_o = 0, no mem_done_o; only the first 2 bytes changed in RAM.
- Back-to-back: IF request held continuously -> no second accept in the done cycle; the second fetch starts exactly one cycle after the done cycle.

Source files
------------

// File: rtl/mem_ctrl_if.sv
// Request/response and RAM-side signal bundle for mem_ctrl.
// slave = controller side, master = requesters plus RAM model.
interface mem_ctrl_if #(
    parameter int ADDR_WIDTH = 17
);
    logic                  if_req_i;
    logic [31:0]           if_addr_i;
    logic                  if_done_o;
    logic [31:0]           if_inst_o;
    logic                  mem_req_i;
    logic                  mem_we_i;
    logic [1:0]            mem_len_i;
    logic [31:0]           mem_addr_i;
    logic [31:0]           mem_data_i;
    logic                  mem_done_o;
    logic [31:0]           mem_data_o;
    logic                  busy_o;
    logic                  ram_we_o;
    logic [ADDR_WIDTH-1:0] ram_addr_o;
    logic [7:0]            ram_data_o;
    logic [7:0]            ram_data_i;

    modport slave (
        input  if_req_i, if_addr_i,
        input  mem_req_i, mem_we_i, mem_len_i,
        input  mem_addr_i, mem_data_i,
        input  ram_data_i,
        output if_done_o, if_inst_o,
        output mem_done_o, mem_data_o,
        output busy_o,
        output ram_we_o, ram_addr_o, ram_data_o
    );

    modport master (
        output if_req_i, if_addr_i,
        output mem_req_i, mem_we_i, mem_len_i,
        output mem_addr_i, mem_data_i,
        output ram_data_i,
        input  if_done_o, if_inst_o,
        input  mem_done_o, mem_data_o,
        input  busy_o,
        input  ram_we_o, ram_addr_o, ram_data_o
    );
endinterface

// File: rtl/mem_ctrl.sv
// Arbitrates IF/MEM requests onto a byte-wide synchronous RAM,
// serialising little-endian accesses and reassembling read data.
module mem_ctrl #(
    parameter int ADDR_WIDTH = 17
) (
    input logic       clk,
    input logic       rst_n,
    mem_ctrl_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        DRAIN
    } state_t;

    state_t                r_state;
    logic                  r_is_if;
    logic                  r_we;
    logic [ADDR_WIDTH-1:0] r_base;
    logic [1:0]            r_last;
    logic [1:0]            r_idx;
    logic [31:0]           r_wdata;
    logic [31:0]           r_rbuf;
    logic                  r_if_done;
    logic                  r_mem_done;
    logic [31:0]           r_if_inst;
    logic [31:0]           r_mem_data;
    logic                  r_ram_we;
    logic [ADDR_WIDTH-1:0] r_ram_addr;
    logic [7:0]            r_ram_data;

    logic                  w_accept;
    logic                  w_mem_wr;
    logic [ADDR_WIDTH-1:0] w_req_base;
    logic [1:0]            w_nidx;
    logic [ADDR_WIDTH-1:0] w_next_addr;
    logic [7:0]            w_next_byte;
    logic [1:0]            w_cap_pos;
    logic [31:0]           w_rbuf_next;
    logic                  w_unused;

    // A done output high means the requester is still dropping its request.
    assign w_accept = (r_state == IDLE) && !r_if_done && !r_mem_done
                   && (bus.mem_req_i || bus.if_req_i);
    assign w_mem_wr = bus.mem_req_i && bus.mem_we_i;
    assign w_req_base = bus.mem_req_i ? bus.mem_addr_i[ADDR_WIDTH-1:0]
                                      : bus.if_addr_i[ADDR_WIDTH-1:0];

    assign w_nidx      = r_idx + 2'd1;
    assign w_next_addr = r_base + {{(ADDR_WIDTH-2){1'b0}}, w_nidx};
    assign w_next_byte = 8'(r_wdata >> {w_nidx, 3'b000});

    // RAM data lags the issued address by two edges.
    assign w_cap_pos   = (r_state == DRAIN) ? r_idx : r_idx - 2'd1;
    assign w_rbuf_next = r_rbuf
                       | (32'(bus.ram_data_i) << {w_cap_pos, 3'b000});

    assign w_unused = &{1'b0, bus.if_addr_i[31:ADDR_WIDTH],
                        bus.mem_addr_i[31:ADDR_WIDTH]};

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_is_if    <= 1'b0;
            r_we       <= 1'b0;
            r_base     <= '0;
            r_last     <= 2'd0;
            r_idx      <= 2'd0;
            r_wdata    <= 32'd0;
            r_rbuf     <= 32'd0;
            r_if_done  <= 1'b0;
            r_mem_done <= 1'b0;
            r_if_inst  <= 32'd0;
            r_mem_data <= 32'd0;
            r_ram_we   <= 1'b0;
            r_ram_addr <= '0;
            r_ram_data <= 8'd0;
        end else begin
            r_if_done  <= 1'b0;
            r_mem_done <= 1'b0;
            unique case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_is_if    <= !bus.mem_req_i;
                        r_we       <= w_mem_wr;
                        r_base     <= w_req_base;
                        r_last     <= bus.mem_req_i ? bus.mem_len_i : 2'd3;
                        r_wdata    <= bus.mem_data_i;
                        r_idx      <= 2'd0;
                        r_rbuf     <= 32'd0;
                        r_ram_addr <= w_req_base;
                        r_ram_we   <= w_mem_wr;
                        r_ram_data <= w_mem_wr ? bus.mem_data_i[7:0] : 8'd0;
                        r_state    <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (r_idx != 2'd0) begin
                        r_rbuf <= w_rbuf_next;
                    end
                    if (r_idx != r_last) begin
                        r_idx      <= w_nidx;
                        r_ram_addr <= w_next_addr;
                        if (r_we) begin
                            r_ram_data <= w_next_byte;
                        end
                    end else if (r_we) begin
                        r_ram_we   <= 1'b0;
                        r_mem_done <= 1'b1;
                        r_state    <= IDLE;
                    end else begin
                        r_state <= DRAIN;
                    end
                end
                DRAIN: begin
                    r_state <= IDLE;
                    if (r_is_if) begin
                        r_if_inst <= w_rbuf_next;
                        r_if_done <= 1'b1;
                    end else begin
                        r_mem_data <= w_rbuf_next;
                        r_mem_done <= 1'b1;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.if_done_o  = r_if_done;
    assign bus.if_inst_o  = r_if_inst;
    assign bus.mem_done_o = r_mem_done;
    assign bus.mem_data_o = r_mem_data;
    assign bus.busy_o     = (r_state != IDLE);
    assign bus.ram_we_o   = r_ram_we;
    assign bus.ram_addr_o = r_ram_addr;
    assign bus.ram_data_o = r_ram_data;
endmodule

// File: tb/tb_mem_ctrl.sv
// Bench for mem_ctrl: byte RAM model, directed vector table,
// hand-written arbitration/reset/back-to-back sequences, random traffic.
module tb_mem_ctrl;
    localparam int AW   = 17;
    localparam int MASK = (1 << AW) - 1;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    mem_ctrl_if #(.ADDR_WIDTH(AW)) bus ();

    mem_ctrl #(.ADDR_WIDTH(AW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Byte-wide synchronous RAM, one-cycle read latency
    bit [7:0] ram [0:MASK];
    always @(posedge clk) begin
        if (bus.ram_we_o === 1'b1) ram[bus.ram_addr_o] <= bus.ram_data_o;
        bus.ram_data_i <= ram[bus.ram_addr_o];
    end

    bit [7:0]    model [0:MASK];
    logic [31:0] exp_if_q  = 32'd0;
    logic [31:0] exp_mem_q = 32'd0;
    int          n_tests   = 0;
    int          n_fail    = 0;

    typedef struct {
        bit          is_if;
        bit          we;
        logic [1:0]  len;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp;
    } vec_t;

    vec_t tbl [12];

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] model_read(input logic [31:0] addr,
                                               input int n);
        logic [31:0] d;
        d = 32'd0;
        for (int i = 0; i < n; i++)
            d[8*i +: 8] = model[(addr + 32'(i)) & MASK];
        return d;
    endfunction

    task automatic wait_done(input bit is_if, output int lat);
        lat = -1;
        for (int c = 1; c <= 20; c++) begin
            step();
            if ((is_if ? bus.if_done_o : bus.mem_done_o) === 1'b1) begin
                lat = c;
                break;
            end
        end
    endtask

    // One complete transaction, checked for address/data sequence,
    // latency, result and output hold behaviour.
    task automatic txn(input string tag, input bit is_if, input bit we,
                       input logic [1:0] len, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [31:0] exp_rd);
        int n;
        int k;
        int lat;
        int exp_lat;
        bit seq_ok;
        bit done;
        bit wrong;
        bit wr;
        logic [31:0] rdata;
        n       = is_if ? 4 : int'(len) + 1;
        wr      = we && !is_if;
        exp_lat = wr ? n : n + 1;
        k = -1; lat = -1; seq_ok = 1; done = 0; wrong = 0;
        rdata = 32'd0;
        if (is_if) begin
            bus.if_req_i  = 1'b1;
            bus.if_addr_i = addr;
        end else begin
            bus.mem_req_i  = 1'b1;
            bus.mem_we_i   = we;
            bus.mem_len_i  = len;
            bus.mem_addr_i = addr;
            bus.mem_data_i = wdata;
        end
        for (int c = 0; c < 40 && !done; c++) begin
            step();
            if (k < 0 && bus.busy_o === 1'b1) k = 0;
            else if (k >= 0) k++;
            if (k >= 0 && k < n) begin
                if (bus.ram_addr_o !== AW'((addr + 32'(k)) & MASK)) seq_ok = 0;
                if (bus.ram_we_o !== wr) seq_ok = 0;
                if (wr && bus.ram_data_o !== wdata[8*k +: 8]) seq_ok = 0;
            end
            if (k >= n && bus.ram_we_o !== 1'b0) seq_ok = 0;
            if ((is_if ? bus.mem_done_o : bus.if_done_o) === 1'b1) wrong = 1;
            if ((is_if ? bus.if_done_o : bus.mem_done_o) === 1'b1) begin
                done  = 1;
                lat   = k;
                rdata = is_if ? bus.if_inst_o : bus.mem_data_o;
            end
        end
        bus.if_req_i  = 1'b0;
        bus.mem_req_i = 1'b0;
        check({tag, " seq"}, 32'(seq_ok), 32'd1);
        check({tag, " lat"}, lat, exp_lat);
        check({tag, " other_done"}, 32'(wrong), 32'd0);
        if (wr) begin
            for (int i = 0; i < n; i++)
                model[(addr + 32'(i)) & MASK] = wdata[8*i +: 8];
        end else begin
            check({tag, " rdata"}, rdata, exp_rd);
            if (is_if) exp_if_q = exp_rd;
            else exp_mem_q = exp_rd;
        end
        step();
        check({tag, " pulse"},
              {30'd0, bus.if_done_o | bus.mem_done_o, bus.busy_o}, 32'd0);
        check({tag, " hold_if"}, bus.if_inst_o, exp_if_q);
        check({tag, " hold_mem"}, bus.mem_data_o, exp_mem_q);
    endtask

    initial begin
        int lat;
        bus.if_req_i   = 1'b0;
        bus.if_addr_i  = 32'd0;
        bus.mem_req_i  = 1'b0;
        bus.mem_we_i   = 1'b0;
        bus.mem_len_i  = 2'd0;
        bus.mem_addr_i = 32'd0;
        bus.mem_data_i = 32'd0;

        tbl[0]  = '{0, 1, 2'd3, 32'h0000_0100, 32'h4433_2211, 32'h0};
        tbl[1]  = '{1, 0, 2'd0, 32'h0000_0100, 32'h0, 32'h4433_2211};
        tbl[2]  = '{0, 1, 2'd3, 32'h0000_0200, 32'hDEAD_BEEF, 32'h0};
        tbl[3]  = '{0, 0, 2'd3, 32'h0000_0200, 32'h0, 32'hDEAD_BEEF};
        tbl[4]  = '{0, 0, 2'd0, 32'h0000_0201, 32'h0, 32'h0000_00BE};
        tbl[5]  = '{0, 1, 2'd1, 32'h0001_FFFF, 32'hCCCC_A1B2, 32'h0};
        tbl[6]  = '{0, 0, 2'd1, 32'h0001_FFFF, 32'h0, 32'h0000_A1B2};
        tbl[7]  = '{0, 0, 2'd0, 32'h0000_0000, 32'h0, 32'h0000_00A1};
        tbl[8]  = '{0, 0, 2'd2, 32'h0000_0202, 32'h0, 32'h0000_DEAD};
        tbl[9]  = '{0, 1, 2'd0, 32'hFFFE_0300, 32'h0000_005A, 32'h0};
        tbl[10] = '{0, 0, 2'd0, 32'h0000_0300, 32'h0, 32'h0000_005A};
        tbl[11] = '{1, 0, 2'd0, 32'h0001_FFFE, 32'h0, 32'h00A1_B200};

        // Reset state
        step();
        step();
        check("rst busy", 32'(bus.busy_o), 32'd0);
        check("rst we", 32'(bus.ram_we_o), 32'd0);
        check("rst addr", 32'(bus.ram_addr_o), 32'd0);
        check("rst wdata", 32'(bus.ram_data_o), 32'd0);
        check("rst done", {30'd0, bus.if_done_o, bus.mem_done_o}, 32'd0);
        check("rst inst", bus.if_inst_o, 32'd0);
        check("rst mdata", bus.mem_data_o, 32'd0);
        rst_n = 1'b1;
        step();

        for (int v = 0; v < 12; v++)
            txn($sformatf("vec%0d", v), tbl[v].is_if, tbl[v].we,
                tbl[v].len, tbl[v].addr, tbl[v].wdata, tbl[v].exp);

        // Simultaneous requests: MEM wins, IF follows after the gap cycle
        bus.mem_req_i  = 1'b1;
        bus.mem_we_i   = 1'b0;
        bus.mem_len_i  = 2'd0;
        bus.mem_addr_i = 32'h0000_0201;
        bus.if_req_i   = 1'b1;
        bus.if_addr_i  = 32'h0000_0100;
        step();
        check("arb pick", 32'(bus.ram_addr_o), 32'h201);
        wait_done(1'b0, lat);
        check("arb mem lat", lat, 32'd2);
        check("arb mem data", bus.mem_data_o, 32'h0000_00BE);
        check("arb if idle", 32'(bus.if_done_o), 32'd0);
        bus.mem_req_i = 1'b0;
        step();
        check("arb gap", 32'(bus.busy_o), 32'd0);
        step();
        check("arb if start", {bus.busy_o, 15'd0, 16'(bus.ram_addr_o)},
              {1'b1, 15'd0, 16'h0100});
        wait_done(1'b1, lat);
        check("arb if lat", lat, 32'd5);
        check("arb if data", bus.if_inst_o, 32'h4433_2211);
        bus.if_req_i = 1'b0;
        exp_mem_q = 32'h0000_00BE;
        exp_if_q  = 32'h4433_2211;
        step();

        // IF request held across completion
        bus.if_req_i  = 1'b1;
        bus.if_addr_i = 32'h0000_0200;
        step();
        check("b2b start", 32'(bus.busy_o), 32'd1);
        wait_done(1'b1, lat);
        check("b2b lat1", lat, 32'd5);
        check("b2b data1", bus.if_inst_o, 32'hDEAD_BEEF);
        step();
        check("b2b gap", {30'd0, bus.busy_o, bus.if_done_o}, 32'd0);
        step();
        check("b2b restart", {bus.busy_o, 15'd0, 16'(bus.ram_addr_o)},
              {1'b1, 15'd0, 16'h0200});
        wait_done(1'b1, lat);
        check("b2b lat2", lat, 32'd5);
        bus.if_req_i = 1'b0;
        exp_if_q = 32'hDEAD_BEEF;
        step();

        // Reset after two of four bytes reach the RAM
        bus.mem_req_i  = 1'b1;
        bus.mem_we_i   = 1'b1;
        bus.mem_len_i  = 2'd3;
        bus.mem_addr_i = 32'h0000_0400;
        bus.mem_data_i = 32'h1122_3344;
        step();
        check("rstw busy", 32'(bus.busy_o), 32'd1);
        step();
        rst_n = 1'b0;
        step();
        check("rstw we", 32'(bus.ram_we_o), 32'd0);
        check("rstw busy0", 32'(bus.busy_o), 32'd0);
        check("rstw done", 32'(bus.mem_done_o), 32'd0);
        check("rstw mdata", bus.mem_data_o, 32'd0);
        bus.mem_req_i = 1'b0;
        rst_n = 1'b1;
        step();
        check("rstw late done", 32'(bus.mem_done_o), 32'd0);
        model[32'h400] = 8'h44;
        model[32'h401] = 8'h33;
        exp_mem_q = 32'd0;
        exp_if_q  = 32'd0;
        txn("rstw readback", 1'b0, 1'b0, 2'd3, 32'h0000_0400, 32'd0,
            32'h0000_3344);

        // Random traffic against the byte-array model
        for (int t = 0; t < 80; t++) begin
            bit          r_if;
            bit          r_we;
            logic [1:0]  r_len;
            logic [31:0] r_addr;
            logic [31:0] r_low;
            int          r_n;
            r_if  = ($urandom_range(0, 3) == 0);
            r_we  = !r_if && ($urandom_range(0, 1) == 1);
            r_len = 2'($urandom_range(0, 3));
            case ($urandom_range(0, 2))
                0:       r_low = 32'h500 + $urandom_range(0, 31);
                1:       r_low = 32'h1FFF8 + $urandom_range(0, 7);
                default: r_low = 32'h100 + $urandom_range(0, 15);
            endcase
            r_addr = ($urandom() & ~32'(MASK)) | r_low;
            r_n = r_if ? 4 : int'(r_len) + 1;
            txn($sformatf("rnd%0d", t), r_if, r_we, r_len, r_addr,
                $urandom(), model_read(r_addr, r_n));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
